alu_op_sequencer: RTL

Command-driven front end for the registered 8-bit `alu`. Accepts one operation at a time from an upstream valid/ready command port and drives the ALU operand and select inputs. It waits out the ALU's fixed latency, captures `ALU_Out`/`CarryOut`, and returns them on a valid/ready response port. Division by zero is trapped locally, and completed and trapped operations are counted. It is the initiator side of the ALU port, replacing bench-driven stimulus in system builds.

---
 rtl/alu_op_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Command-driven front end for the registered 8-bit ALU: issues one operation at a time,
// waits out the ALU latency, traps divide-by-zero and returns results over valid/ready.
module alu_op_sequencer #(
   parameter int ALU_LATENCY = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_a,
   input  logic [7:0]       cmd_b,
   input  logic [3:0]       cmd_sel,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [3:0]       alu_sel,
   input  logic [7:0]       alu_out,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_result,
   output logic             rsp_carry,
   output logic [3:0]       rsp_sel,
   output logic             rsp_error,
   output logic [CNT_W-1:0] op_count,
   output logic [7:0]       err_count
);

   typedef enum logic [1:0] {IDLE, WAIT, TRAP, RESP} state_e;

   // The extra count covers the edge on which the ALU samples alu_*; a trap is timed
   // to answer two edges after acceptance, the same as a single-cycle ALU op.
   localparam logic [2:0] WAIT_LOAD = 3'(ALU_LATENCY + 1);
   localparam logic [2:0] TRAP_LOAD = 3'd2;

   state_e           state_q, state_d;
   logic [2:0]       waitCnt_q, waitCnt_d;
   logic [7:0]       aluA_q, aluA_d;
   logic [7:0]       aluB_q, aluB_d;
   logic [3:0]       aluSel_q, aluSel_d;
   logic [7:0]       rspResult_q, rspResult_d;
   logic             rspCarry_q, rspCarry_d;
   logic [3:0]       rspSel_q, rspSel_d;
   logic             rspError_q, rspError_d;
   logic [CNT_W-1:0] opCount_q, opCount_d;
   logic [7:0]       errCount_q, errCount_d;
   logic             cmdFire;
   logic             rspFire;
   logic             divByZero;

   assign cmd_ready  = reset && (state_q == IDLE);
   assign rsp_valid  = (state_q == RESP);
   assign cmdFire    = cmd_valid && cmd_ready;
   assign rspFire    = rsp_valid && rsp_ready;
   assign divByZero  = (cmd_sel == 4'b0011) && (cmd_b == 8'd0);

   assign alu_a      = aluA_q;
   assign alu_b      = aluB_q;
   assign alu_sel    = aluSel_q;
   assign rsp_result = rspResult_q;
   assign rsp_carry  = rspCarry_q;
   assign rsp_sel    = rspSel_q;
   assign rsp_error  = rspError_q;
   assign op_count   = opCount_q;
   assign err_count  = errCount_q;

   always_comb begin
      state_d     = state_q;
      waitCnt_d   = waitCnt_q;
      aluA_d      = aluA_q;
      aluB_d      = aluB_q;
      aluSel_d    = aluSel_q;
      rspResult_d = rspResult_q;
      rspCarry_d  = rspCarry_q;
      rspSel_d    = rspSel_q;
      rspError_d  = rspError_q;
      opCount_d   = opCount_q;
      errCount_d  = errCount_q;
      case (state_q)
         IDLE: begin
            if (cmdFire) begin
               rspSel_d = cmd_sel;
               if (divByZero) begin
                  // Zeroed operands keep the ALU from ever seeing the trapped divide.
                  aluA_d    = 8'd0;
                  aluB_d    = 8'd0;
                  aluSel_d  = 4'd0;
                  waitCnt_d = TRAP_LOAD;
                  state_d   = TRAP;
               end else begin
                  aluA_d    = cmd_a;
                  aluB_d    = cmd_b;
                  aluSel_d  = cmd_sel;
                  waitCnt_d = WAIT_LOAD;
                  state_d   = WAIT;
               end
            end
         end
         WAIT: begin
            waitCnt_d = waitCnt_q - 3'd1;
            if (waitCnt_q == 3'd1) begin
               rspResult_d = alu_out;
               rspCarry_d  = alu_carry;
               rspError_d  = 1'b0;
               state_d     = RESP;
            end
         end
         TRAP: begin
            waitCnt_d = waitCnt_q - 3'd1;
            if (waitCnt_q == 3'd1) begin
               rspResult_d = 8'd0;
               rspCarry_d  = 1'b0;
               rspError_d  = 1'b1;
               if (errCount_q != 8'hFF) begin
                  errCount_d = errCount_q + 8'd1;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            if (rspFire) begin
               opCount_d = opCount_q + CNT_W'(1);
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         waitCnt_q   <= '0;
         aluA_q      <= '0;
         aluB_q      <= '0;
         aluSel_q    <= '0;
         rspResult_q <= '0;
         rspCarry_q  <= 1'b0;
         rspSel_q    <= '0;
         rspError_q  <= 1'b0;
         opCount_q   <= '0;
         errCount_q  <= '0;
      end else begin
         state_q     <= state_d;
         waitCnt_q   <= waitCnt_d;
         aluA_q      <= aluA_d;
         aluB_q      <= aluB_d;
         aluSel_q    <= aluSel_d;
         rspResult_q <= rspResult_d;
         rspCarry_q  <= rspCarry_d;
         rspSel_q    <= rspSel_d;
         rspError_q  <= rspError_d;
         opCount_q   <= opCount_d;
         errCount_q  <= errCount_d;
      end
   end

endmodule
